// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the serial ALU.
//   - Opcode encodings for the 3-bit operation field (000 and 111 are invalid).
//   - FSM state encoding for alu_serial_ctrl.
//   - Small opcode classification helpers.
package alu_pkg;

   localparam logic [2:0] OpAnd = 3'b001;
   localparam logic [2:0] OpOr  = 3'b010;
   localparam logic [2:0] OpAdd = 3'b011;
   localparam logic [2:0] OpSub = 3'b100;
   localparam logic [2:0] OpNor = 3'b101;
   localparam logic [2:0] OpSlt = 3'b110;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   // Operations that go through the adder and produce carry/overflow.
   function automatic logic is_arith(input logic [2:0] op);
      return (op == OpAdd) || (op == OpSub) || (op == OpSlt);
   endfunction

   // Operations computed as A + ~B + 1.
   function automatic logic is_subtract(input logic [2:0] op);
      return (op == OpSub) || (op == OpSlt);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice.
// Ports:
//   a, b               operand bits
//   less               value driven onto result for SLT
//   a_invert, b_invert invert the operand bit before use
//   cin                carry in
//   operation          opcode (alu_pkg encoding)
//   result             result bit (0 for invalid opcodes)
//   cout               carry out; 0 for non-arithmetic and invalid opcodes
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       less,
   input  logic       a_invert,
   input  logic       b_invert,
   input  logic       cin,
   input  logic [2:0] operation,
   output logic       result,
   output logic       cout
);

   logic ai;
   logic bi;
   logic sum;
   logic carry;

   always_comb begin
      ai    = a ^ a_invert;
      bi    = b ^ b_invert;
      sum   = ai ^ bi ^ cin;
      carry = (ai & bi) | (cin & (ai ^ bi));

      result = 1'b0;
      cout   = 1'b0;
      case (operation)
         OpAnd: result = ai & bi;
         OpOr:  result = ai | bi;
         OpNor: result = ~(ai | bi);
         OpAdd, OpSub: begin
            result = sum;
            cout   = carry;
         end
         OpSlt: begin
            result = less;
            cout   = carry;
         end
         default: begin
            result = 1'b0;
            cout   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU, one operand bit per cycle, LSB first.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin an operation (accepted only in IDLE)
//   operation[2:0]      opcode (alu_pkg encoding)
//   src1, src2          operands, latched on the accepting edge
//   result              registered final result
//   zero, cout, overflow registered flags
//   busy, done          busy in RUN, done for the single DONE cycle
//   check[3:0]          only with ALU_SERIAL_CHECK_EN defined:
//                       {bit carry-out, A bit, B bit, carry-in} in RUN, else 0
// Timing: start accepted at edge k -> bits processed at edges k+1..k+WIDTH,
// flags/result registered at edge k+WIDTH+1 on entry to DONE.
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       operation,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow,
   output logic             busy,
   output logic             done
`ifdef ALU_SERIAL_CHECK_EN
   ,
   output logic [3:0]       check
`endif
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cmsb_q, cmsb_d;     // carry into the MSB
   logic             last_q, last_d;     // all bits processed, finalize next
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             slice_res;
   logic             slice_cout;
   logic [2:0]       slice_op;
   logic             fin_ovf;
   logic [WIDTH-1:0] fin_res;

   // SLT runs the slice as a subtract so the sum bits (and hence the sign)
   // are captured; the less bit is applied once at finalization.
   assign slice_op = (op_q == OpSlt) ? OpSub : op_q;

   alu_bit_slice u_slice (
      .a         (a_q[0]),
      .b         (b_q[0]),
      .less      (1'b0),
      .a_invert  (1'b0),
      .b_invert  (is_subtract(op_q)),
      .cin       (carry_q),
      .operation (slice_op),
      .result    (slice_res),
      .cout      (slice_cout)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      cmsb_d   = cmsb_q;
      last_d   = last_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      fin_ovf  = is_arith(op_q) & (cmsb_q ^ carry_q);
      fin_res  = acc_q;
      if (op_q == OpSlt) begin
         fin_res = {{(WIDTH-1){1'b0}}, acc_q[WIDTH-1] ^ fin_ovf};
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               op_d    = operation;
               a_d     = src1;
               b_d     = src2;
               acc_d   = '0;
               cnt_d   = '0;
               cmsb_d  = 1'b0;
               last_d  = 1'b0;
               carry_d = is_subtract(operation);
            end
         end
         StRun: begin
            if (!last_q) begin
               a_d     = a_q >> 1;
               b_d     = b_q >> 1;
               acc_d   = {slice_res, acc_q[WIDTH-1:1]};
               carry_d = slice_cout;
               if (cnt_q == CntMax) begin
                  cmsb_d = carry_q;
                  last_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end else begin
               state_d  = StDone;
               result_d = fin_res;
               zero_d   = (fin_res == '0);
               cout_d   = is_arith(op_q) & carry_q;
               ovf_d    = fin_ovf;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         cmsb_q   <= 1'b0;
         last_q   <= 1'b0;
         op_q     <= 3'b000;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         cmsb_q   <= cmsb_d;
         last_q   <= last_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);

`ifdef ALU_SERIAL_CHECK_EN
   assign check = (state_q == StRun) ? {slice_cout, a_q[0], b_q[0], carry_q} : 4'b0000;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=32). Inputs change #1 after a
// rising edge; outputs are sampled at the same point.
module tb_alu_serial_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  operation;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] result;
   logic        zero;
   logic        cout;
   logic        overflow;
   logic        busy;
   logic        done;
`ifdef ALU_SERIAL_CHECK_EN
   logic [3:0]  check;
`endif

   int checks = 0;
   int errors = 0;

   alu_serial_ctrl #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .operation (operation),
      .src1      (src1),
      .src2      (src2),
      .result    (result),
      .zero      (zero),
      .cout      (cout),
      .overflow  (overflow),
      .busy      (busy),
      .done      (done)
`ifdef ALU_SERIAL_CHECK_EN
      ,
      .check     (check)
`endif
   );

   always #5 clk = ~clk;

   // Waits one edge (so a preceding DONE drains to IDLE), pulses start, then
   // counts edges after the accepting edge until done rises (0 = timeout).
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      @(posedge clk); #1;
      operation = op; src1 = a; src2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; operation = 3'b000; src1 = '0; src2 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (result !== 32'h0 || zero !== 1'b1 || cout !== 1'b0 || overflow !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got res=%h z=%b c=%b v=%b busy=%b done=%b, want 0 1 0 0 0 0",
                  result, zero, cout, overflow, busy, done);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat;
      do_op(3'b011, 32'h7FFF_FFFF, 32'h0000_0001, lat);
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL add_latency: got %0d edges, want 33", lat);
      end
      checks++;
      if (result !== 32'h8000_0000 || overflow !== 1'b1 || cout !== 1'b0 || zero !== 1'b0) begin
         errors++;
         $display("FAIL add_ovf: got res=%h v=%b c=%b z=%b, want 80000000 1 0 0",
                  result, overflow, cout, zero);
      end
   endtask

   task automatic test_sub();
      int lat;
      do_op(3'b100, 32'h0000_0005, 32'h0000_0005, lat);
      checks++;
      if (lat !== 33 || result !== 32'h0 || zero !== 1'b1 || cout !== 1'b1 ||
          overflow !== 1'b0) begin
         errors++;
         $display("FAIL sub_equal: got lat=%0d res=%h z=%b c=%b v=%b, want 33 0 1 1 0",
                  lat, result, zero, cout, overflow);
      end
   endtask

   task automatic test_slt();
      int lat;
      do_op(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, lat);
      checks++;
      if (lat !== 33 || result !== 32'h0000_0001 || zero !== 1'b0) begin
         errors++;
         $display("FAIL slt_less: got lat=%0d res=%h z=%b, want 33 00000001 0", lat, result, zero);
      end
      do_op(3'b110, 32'h0000_0001, 32'hFFFF_FFFF, lat);
      checks++;
      if (lat !== 33 || result !== 32'h0 || zero !== 1'b1) begin
         errors++;
         $display("FAIL slt_not_less: got lat=%0d res=%h z=%b, want 33 00000000 1",
                  lat, result, zero);
      end
   endtask

   task automatic test_logic();
      logic [2:0]  ops [3] = '{3'b001, 3'b010, 3'b101};
      logic [31:0] exp [3] = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'h000F_000F};
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_op(ops[i], 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
         checks++;
         if (lat !== 33 || result !== exp[i] || cout !== 1'b0 || overflow !== 1'b0 ||
             zero !== 1'b0) begin
            errors++;
            $display("FAIL logic_op%0b: got lat=%0d res=%h c=%b v=%b z=%b, want 33 %h 0 0 0",
                     ops[i], lat, result, cout, overflow, zero, exp[i]);
         end
      end
   endtask

   task automatic test_hold();
      logic [31:0] r;
      r = result;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (result !== 32'h000F_000F || zero !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          r !== 32'h000F_000F) begin
         errors++;
         $display("FAIL hold_idle: got res=%h z=%b busy=%b done=%b, want 000f000f 0 0 0",
                  result, zero, busy, done);
      end
   endtask

   task automatic test_mid_run();
      int lat;
      @(posedge clk); #1;
      operation = 3'b011; src1 = 32'h1234_5678; src2 = 32'h1111_1111; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_accept: got busy=%b done=%b, want 1 0", busy, done);
      end
      repeat (4) @(posedge clk);
      #1;
      // Disturb the operation in flight.
      start = 1'b1; operation = 3'b100; src1 = 32'hFFFF_FFFF; src2 = 32'h0;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      for (int i = 6; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== 33 || result !== 32'h2345_6789 || cout !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_ignore: got lat=%0d res=%h c=%b v=%b, want 33 23456789 0 0",
                  lat, result, cout, overflow);
      end
   endtask

   // done is high now; start raised in the DONE cycle must wait for IDLE.
   task automatic test_back_to_back();
      int lat;
      operation = 3'b011; src1 = 32'h0000_0001; src2 = 32'h0000_0002; start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b, want 1", busy);
      end
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat !== 33 || result !== 32'h0000_0003) begin
         errors++;
         $display("FAIL b2b_result: got lat=%0d res=%h, want 33 00000003", lat, result);
      end
   endtask

   task automatic test_reset_abort();
      int seen_done;
      @(posedge clk); #1;
      operation = 3'b011; src1 = 32'h0000_FFFF; src2 = 32'h0000_0001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1 ||
          cout !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort: got busy=%b done=%b res=%h z=%b c=%b v=%b, want 0 0 0 1 0 0",
                  busy, done, result, zero, cout, overflow);
      end
      // Reset wins over a simultaneous start.
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_over_start: got busy=%b, want 0", busy);
      end
      rst = 1'b0;
      start = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         errors++;
         $display("FAIL reset_no_done: got %0d active cycles, want 0", seen_done);
      end
   endtask

   task automatic test_invalid();
      int lat;
      do_op(3'b011, 32'h0000_0010, 32'h0000_0020, lat);
      do_op(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
      checks++;
      if (lat !== 33 || result !== 32'h0 || zero !== 1'b1 || cout !== 1'b0 ||
          overflow !== 1'b0) begin
         errors++;
         $display("FAIL invalid_op: got lat=%0d res=%h z=%b c=%b v=%b, want 33 0 1 0 0",
                  lat, result, zero, cout, overflow);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_slt();
      test_logic();
      test_hold();
      test_mid_run();
      test_back_to_back();
      test_reset_abort();
      test_invalid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits, range 2..32.
REQ-002 SHALL have port clk, input, 1, the only system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port operation, input, 3, opcode: AND=001, OR=010, ADD=011, SUB=100, NOR=101, SLT=110; all other codes are invalid.
REQ-006 SHALL have ports src1 and src2, input, WIDTH, operands.
REQ-007 SHALL have port result, output, WIDTH, registered final result.
REQ-008 SHALL have ports zero, cout and overflow, output, 1 each, registered flags.
REQ-009 SHALL have ports busy and done, output, 1 each; busy is high in RUN, done is high only in DONE.

Function
REQ-010 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-011 SHALL latch operation, src1 and src2 and enter RUN on an edge in IDLE with start=1; start SHALL be ignored in RUN and DONE.
REQ-012 SHALL process one bit per RUN cycle, LSB first, using a bit counter 0..WIDTH-1 and a 1-bit carry register.
REQ-013 SHALL initialise carry to 1 for SUB and SLT, and to 0 for all other opcodes, with the B bit inverted for SUB and SLT.
REQ-014 SHALL compute AND, OR and NOR bitwise, with carry held at 0.
REQ-015 SHALL compute ADD, SUB and SLT as full-add of the A bit, the (possibly inverted) B bit and the carry.
REQ-016 SHALL, for SLT, produce result = {WIDTH-1 zeros, sign XOR overflow} of src1-src2 on entry to DONE.
REQ-017 SHALL, for an invalid opcode, produce result=0 and cout=overflow=0, with normal latency.
REQ-018 SHALL go RUN->DONE after bit WIDTH-1, and DONE->IDLE after exactly one cycle.
REQ-019 SHALL assert done in the cycle WIDTH+1 edges after the accepting edge; with WIDTH=32, start accepted at edge k gives done high between edges k+33 and k+34.
REQ-020 SHALL set cout to the carry out of bit WIDTH-1 for ADD, SUB and SLT, and to 0 otherwise.
REQ-021 SHALL set overflow to carry-into-MSB XOR carry-out-of-MSB for ADD, SUB and SLT, and to 0 otherwise.
REQ-022 SHALL set zero to 1 when the final result is 0.
REQ-023 SHALL hold result, zero, cout and overflow stable from DONE until the next accepted start.
REQ-024 SHALL change src1 and src2 during RUN without affecting the operation in flight.
REQ-025 SHALL accept start asserted in the same cycle DONE->IDLE only at the following IDLE edge.

Reset
REQ-026 SHALL, with rst=1 at an edge, force IDLE, clear counter and carry, and set result=0, zero=1, cout=0, overflow=0, busy=0, done=0.
REQ-027 SHALL abort an in-flight RUN on reset with no done pulse, and rst SHALL take priority over start.

Configuration
REQ-028 SHALL, with macro ALU_SERIAL_CHECK_EN defined, add output port check[3:0] = {carry-out of current bit, current A bit, current B bit, current carry-in}, valid in RUN and 0 elsewhere.
REQ-029 SHALL, without ALU_SERIAL_CHECK_EN, omit the check port and its logic, with all other behaviour identical.

Structure
REQ-030 SHALL place the opcode constants and the FSM state encoding in shared package alu_pkg.
REQ-031 SHALL instantiate one combinational 1-bit slice sub-module alu_bit_slice (inputs: a, b, less, a_invert, b_invert, cin, operation; outputs: result, cout) for the per-bit datapath.
REQ-032 SHALL keep the FSM, counter, shift registers and flags in alu_serial_ctrl.

Verification
REQ-033 SHALL cover ADD: 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow=1, cout=0, zero=0, done 33 edges after start.
REQ-034 SHALL cover SUB: 0x00000005-0x00000005 -> result 0, zero=1, cout=1, overflow=0.
REQ-035 SHALL cover SLT: src1=0xFFFFFFFF(-1), src2=0x00000001 -> result 0x00000001; swapped operands -> result 0x00000000.
REQ-036 SHALL cover AND/OR/NOR on 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0x000F000F, with cout=overflow=0.
REQ-037 SHALL cover a second start pulsed mid-RUN, which is ignored, and src1 changed mid-RUN, which leaves the result unchanged.
REQ-038 SHALL cover rst asserted at bit 10 of an ADD, giving IDLE next cycle, no done and all outputs at reset values; and opcode 111, giving result 0 with done.
